// File: rtl/hls_run_pkg.sv
// Shared types and constants for the HLS kernel run sequencer.
package hls_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KRST,
    ST_START,
    ST_WAIT,
    ST_REPORT,
    ST_NEXT
  } state_t;

  typedef enum logic [1:0] {
    STAT_PASS    = 2'd0,
    STAT_TIMEOUT = 2'd1,
    STAT_ABORT   = 2'd2
  } status_t;

  localparam int KRST_LEN = 2;

  // Lowest set bit of mask at or above position from; bit 3 of the result flags a hit.
  function automatic logic [3:0] next_set_bit(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/hls_run_watchdog.sv
// Per-run cycle counter with timeout compare; count is the inclusive cycle
// number of the current cycle, with the start cycle counted as cycle 1.
module hls_run_watchdog #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] timeout,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (load)   cnt <= CNT_W'(1);
    else if (enable) cnt <= cnt + CNT_W'(1);
  end

  assign count   = cnt + CNT_W'(1);
  assign expired = (count >= timeout);

endmodule

// File: rtl/hls_run_sequencer.sv
// Runs each enabled HLS kernel channel cfg_runs times, timing and reporting every run.
// Optional run statistics outputs are enabled with `define HLS_RUN_STATS_EN.
module hls_run_sequencer
  import hls_run_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int RUNS_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  input  logic [NUM_CH-1:0] cfg_ch_mask,
  input  logic [RUNS_W-1:0] cfg_runs,
  input  logic [CNT_W-1:0]  cfg_timeout,
  output logic              k_reset,
  output logic [NUM_CH-1:0] start_port,
  input  logic [NUM_CH-1:0] done_port,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_ch,
  output logic [1:0]        res_status,
  output logic [CNT_W-1:0]  res_cycles,
  output logic              busy,
  output logic              seq_done
`ifdef HLS_RUN_STATS_EN
  ,
  output logic [CNT_W-1:0]        stat_min,
  output logic [CNT_W-1:0]        stat_max,
  output logic [CNT_W+RUNS_W-1:0] stat_sum
`endif
);

  state_t            state, state_nxt;
  logic [1:0]        krst_cnt;
  logic              rst_seen, abort_lo, need_krst;
  logic [NUM_CH-1:0] cfg_mask_q;
  logic [RUNS_W-1:0] cfg_runs_q, run_idx;
  logic [CNT_W-1:0]  cfg_timeout_q, count;
  logic [2:0]        ch;
  logic [7:0]        mask8, in8, done8, start8;
  logic [3:0]        nb, first_nb;
  logic              done_cur, expired, run_last;
  logic              go_ok, go_empty, cap, run_adv, ch_adv, seq_end;
  status_t           cap_status;
  logic [CNT_W-1:0]  cap_cycles;

  always_comb begin
    mask8 = '0;
    in8   = '0;
    done8 = '0;
    mask8[NUM_CH-1:0] = cfg_mask_q;
    in8[NUM_CH-1:0]   = cfg_ch_mask;
    done8[NUM_CH-1:0] = done_port;
  end

  assign done_cur = done8[ch];
  assign start8   = 8'd1 << ch;
  assign nb       = next_set_bit(mask8, {1'b0, ch} + 4'd1);
  assign first_nb = next_set_bit(in8, 4'd0);
  assign run_last = ((run_idx + RUNS_W'(1)) == cfg_runs_q);

  hls_run_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .load    (state == ST_START),
    .enable  ((state == ST_WAIT) && !done_cur),
    .timeout (cfg_timeout_q),
    .count   (count),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Abort wins over everything; in WAIT it still produces an ABORT result.
  always_comb begin
    state_nxt  = state;
    go_ok      = 1'b0;
    go_empty   = 1'b0;
    cap        = 1'b0;
    cap_status = STAT_PASS;
    cap_cycles = '0;
    run_adv    = 1'b0;
    ch_adv     = 1'b0;
    seq_end    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort && go) begin
          if (first_nb[3] && (cfg_runs != '0)) begin
            go_ok     = 1'b1;
            state_nxt = ST_KRST;
          end else begin
            go_empty = 1'b1;
          end
        end
      end
      ST_KRST: begin
        if (abort)                             state_nxt = ST_IDLE;
        else if (krst_cnt == 2'(KRST_LEN - 1)) state_nxt = ST_START;
      end
      ST_START: state_nxt = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort || done_cur || expired) begin
          cap        = 1'b1;
          state_nxt  = ST_REPORT;
          cap_cycles = count;
          if (abort)         cap_status = STAT_ABORT;
          else if (!done_cur) begin
            cap_status = STAT_TIMEOUT;
            cap_cycles = cfg_timeout_q;
          end
        end
      end
      ST_REPORT: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (res_ready) state_nxt = (res_status == STAT_ABORT) ? ST_IDLE : ST_NEXT;
      end
      ST_NEXT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!run_last || nb[3]) begin
          run_adv   = !run_last;
          ch_adv    = run_last;
          state_nxt = need_krst ? ST_KRST : ST_START;
        end else begin
          seq_end   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      krst_cnt      <= '0;
      rst_seen      <= 1'b0;
      abort_lo      <= 1'b0;
      seq_done      <= 1'b0;
      cfg_mask_q    <= '0;
      cfg_runs_q    <= '0;
      cfg_timeout_q <= '0;
      ch            <= '0;
      run_idx       <= '0;
      need_krst     <= 1'b0;
      res_ch        <= '0;
      res_status    <= '0;
      res_cycles    <= '0;
    end else begin
      rst_seen <= 1'b1;
      abort_lo <= abort;
      seq_done <= go_empty | seq_end;
      krst_cnt <= (state == ST_KRST) ? krst_cnt + 2'd1 : 2'd0;
      if (go_ok) begin
        cfg_mask_q    <= cfg_ch_mask;
        cfg_runs_q    <= cfg_runs;
        cfg_timeout_q <= cfg_timeout;
        ch            <= first_nb[2:0];
        run_idx       <= '0;
        need_krst     <= 1'b0;
      end
      if (cap) begin
        res_ch     <= ch;
        res_status <= cap_status;
        res_cycles <= cap_cycles;
        need_krst  <= (cap_status == STAT_TIMEOUT);
      end
      if (run_adv) run_idx <= run_idx + RUNS_W'(1);
      if (ch_adv) begin
        run_idx <= '0;
        ch      <= nb[2:0];
      end
    end
  end

  assign k_reset    = rst_seen && !abort_lo && (state != ST_KRST);
  assign start_port = ((state == ST_START) && !abort) ? start8[NUM_CH-1:0] : '0;
  assign res_valid  = (state == ST_REPORT) && !abort;
  assign busy       = (state != ST_IDLE);

`ifdef HLS_RUN_STATS_EN
  logic [CNT_W+RUNS_W:0] sum_ext;
  assign sum_ext = {1'b0, stat_sum} + (CNT_W+RUNS_W+1)'(cap_cycles);

  // Statistics cover PASS runs only; the sum sticks at all-ones on overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
    end else if (go_ok || go_empty) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
    end else if (cap && (cap_status == STAT_PASS)) begin
      if (cap_cycles < stat_min) stat_min <= cap_cycles;
      if (cap_cycles > stat_max) stat_max <= cap_cycles;
      stat_sum <= sum_ext[CNT_W+RUNS_W] ? '1 : sum_ext[CNT_W+RUNS_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench for hls_run_sequencer: a kernel responder plays planned
// latencies, expected results/starts are queued up front and checked by a monitor.
module tb_hls_run_sequencer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int RUNS_W = 16;
  localparam logic [1:0] S_PASS = 2'd0, S_TMO = 2'd1, S_ABORT = 2'd2;

  logic              clock = 1'b0, reset = 1'b0, go = 1'b0, abort = 1'b0;
  logic [NUM_CH-1:0] cfg_ch_mask = '0, done_port = '0, start_port;
  logic [RUNS_W-1:0] cfg_runs = '0;
  logic [CNT_W-1:0]  cfg_timeout = '0, res_cycles;
  logic              k_reset, res_valid, res_ready = 1'b0, busy, seq_done;
  logic [2:0]        res_ch;
  logic [1:0]        res_status;
`ifdef HLS_RUN_STATS_EN
  logic [CNT_W-1:0]        stat_min, stat_max;
  logic [CNT_W+RUNS_W-1:0] stat_sum;
`endif

  hls_run_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RUNS_W(RUNS_W)) dut (
    .clock(clock), .reset(reset), .go(go), .abort(abort),
    .cfg_ch_mask(cfg_ch_mask), .cfg_runs(cfg_runs), .cfg_timeout(cfg_timeout),
    .k_reset(k_reset), .start_port(start_port), .done_port(done_port),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_status(res_status), .res_cycles(res_cycles), .busy(busy), .seq_done(seq_done)
`ifdef HLS_RUN_STATS_EN
    , .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [2:0] ch; logic [1:0] st; logic [31:0] cyc; } res_t;
  typedef struct packed { logic [2:0] ch; logic [2:0] klow; } start_t;

  res_t   exp_res_q[$];
  start_t exp_start_q[$];
  int     lat_q[$];
  int     plan_q[$];
  int     n_checks = 0, n_fail = 0;
  int     seq_done_cnt = 0, stall_cnt = 0, hold_low = 0, ready_pct = 100;
  int     low_len = 0;
  logic [31:0] exp_min, exp_max;
  logic [47:0] exp_sum;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Kernel model: latency 0 means the kernel never finishes; non-current channels get noise.
  int cyc = 0, due = 0, cur = 0;
  bit active = 1'b0;
  always @(posedge clock) begin
    logic [NUM_CH-1:0] nd;
    logic [7:0]        noise;
    int                lat;
    #1;
    cyc++;
    noise = 8'($urandom);
    nd = '0;
    if (start_port != '0) begin
      for (int i = 0; i < NUM_CH; i++) if (start_port[i]) cur = i;
      lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      active = (lat != 0);
      due = cyc + lat;
      if (noise[7]) nd[cur] = 1'b1;
    end else if (active && cyc == due) begin
      nd[cur] = 1'b1;
      active = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) if (i != cur) nd[i] = noise[i];
    done_port = nd;
  end

  always @(posedge clock) begin
    #1;
    if (hold_low > 0 && res_valid) begin
      res_ready = 1'b0;
      hold_low--;
    end else begin
      res_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: checks starts, k_reset preamble, result stability and scoreboard order.
  logic       held = 1'b0;
  logic [2:0] h_ch;
  logic [1:0] h_st;
  logic [31:0] h_cyc;
  always @(negedge clock) begin
    start_t s;
    res_t   r;
    int     idx;
    if (reset) begin
      if (start_port != '0) begin
        idx = 0;
        for (int i = 0; i < NUM_CH; i++) if (start_port[i]) idx = i;
        check_output("start_onehot", 64'($countones(start_port)), 64'd1);
        if (exp_start_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_start actual_ch=%0d required=none", idx);
        end else begin
          s = exp_start_q.pop_front();
          check_output("start_ch", 64'(idx), 64'(s.ch));
          check_output("start_krst_len", 64'(low_len), 64'(s.klow));
        end
      end
      low_len = k_reset ? 0 : low_len + 1;
      if (res_valid) begin
        check_output("no_start_in_report", 64'(start_port), 64'd0);
        if (held) begin
          check_output("stable_ch", 64'(res_ch), 64'(h_ch));
          check_output("stable_status", 64'(res_status), 64'(h_st));
          check_output("stable_cycles", 64'(res_cycles), 64'(h_cyc));
        end
        if (res_ready) begin
          held = 1'b0;
          if (exp_res_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL unexpected_result actual_ch=%0d status=%0d required=none", res_ch, res_status);
          end else begin
            r = exp_res_q.pop_front();
            check_output("res_ch", 64'(res_ch), 64'(r.ch));
            check_output("res_status", 64'(res_status), 64'(r.st));
            check_output("res_cycles", 64'(res_cycles), 64'(r.cyc));
          end
        end else begin
          held = 1'b1;
          stall_cnt++;
          h_ch = res_ch; h_st = res_status; h_cyc = res_cycles;
        end
      end else begin
        held = 1'b0;
      end
      if (seq_done) seq_done_cnt++;
    end
  end

  // Reference model: derive every start and result of the sequence, then pulse go.
  task automatic apply_stimulus(input logic [3:0] mask, input int runs, input int tmo);
    bit     first = 1'b1, prev_to = 1'b0;
    int     lat;
    res_t   r;
    start_t s;
    exp_min = '1; exp_max = '0; exp_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        for (int k = 0; k < runs; k++) begin
          if (plan_q.size() > 0) lat = plan_q.pop_front();
          else lat = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, tmo + 3));
          s.ch = 3'(c);
          s.klow = (first || prev_to) ? 3'd2 : 3'd0;
          exp_start_q.push_back(s);
          lat_q.push_back(lat);
          first = 1'b0;
          r.ch = 3'(c);
          if (lat != 0 && lat + 1 <= tmo) begin
            r.st = S_PASS; r.cyc = 32'(lat + 1); prev_to = 1'b0;
            if (r.cyc < exp_min) exp_min = r.cyc;
            if (r.cyc > exp_max) exp_max = r.cyc;
            exp_sum = exp_sum + 48'(r.cyc);
          end else begin
            r.st = S_TMO; r.cyc = 32'(tmo); prev_to = 1'b1;
          end
          exp_res_q.push_back(r);
        end
      end
    end
    @(posedge clock); #1;
    cfg_ch_mask = mask; cfg_runs = 16'(runs); cfg_timeout = 32'(tmo); go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    cfg_ch_mask = 4'($urandom); cfg_runs = 16'($urandom_range(0, 5)); cfg_timeout = 32'($urandom_range(1, 60));
  endtask

  task automatic wait_seq_done(input string name, input int budget);
    int base = seq_done_cnt;
    int n = 0;
    while (seq_done_cnt == base && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check_output({name, "_seq_done"}, 64'(seq_done_cnt - base), 64'd1);
    check_output({name, "_results_left"}, 64'(exp_res_q.size()), 64'd0);
    check_output({name, "_starts_left"}, 64'(exp_start_q.size()), 64'd0);
    check_output({name, "_idle"}, 64'(busy), 64'd0);
`ifdef HLS_RUN_STATS_EN
    check_output({name, "_stat_min"}, 64'(stat_min), 64'(exp_min));
    check_output({name, "_stat_max"}, 64'(stat_max), 64'(exp_max));
    check_output({name, "_stat_sum"}, 64'(stat_sum), 64'(exp_sum));
`endif
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int     n;
    start_t s;
    res_t   r;
    repeat (4) @(posedge clock);
    #1;
    check_output("rst_k_reset", 64'(k_reset), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_res_valid", 64'(res_valid), 64'd0);
    check_output("rst_start_port", 64'(start_port), 64'd0);
    check_output("rst_seq_done", 64'(seq_done), 64'd0);
    check_output("rst_res_fields", 64'({res_ch, res_status, res_cycles}), 64'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check_output("k_reset_release", 64'(k_reset), 64'd1);

    $display("[TB] two channels, two runs each, done after 9 cycles");
    plan_q = '{9, 9, 9, 9};
    apply_stimulus(4'b0101, 2, 100);
    wait_seq_done("basic", 2000);

    $display("[TB] timeout then pass on channel 0");
    plan_q = '{0, 5};
    apply_stimulus(4'b0001, 2, 50);
    wait_seq_done("timeout", 2000);

    $display("[TB] done on the timeout cycle");
    plan_q = '{19};
    apply_stimulus(4'b0010, 1, 20);
    wait_seq_done("tie", 2000);

    $display("[TB] result held by 7 cycles of backpressure");
    stall_cnt = 0;
    hold_low = 7;
    plan_q = '{3};
    apply_stimulus(4'b1000, 1, 10);
    wait_seq_done("stall", 2000);
    check_output("stall_len", 64'(stall_cnt), 64'd7);

    $display("[TB] abort during WAIT");
    s.ch = 3'd0; s.klow = 3'd2; exp_start_q.push_back(s);
    lat_q.push_back(0);
    r.ch = 3'd0; r.st = S_ABORT; r.cyc = 32'd6; exp_res_q.push_back(r);
    @(posedge clock); #1;
    cfg_ch_mask = 4'b0001; cfg_runs = 16'd1; cfg_timeout = 32'd100; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    n = 0;
    while (start_port == '0 && n < 50) begin @(negedge clock); n++; end
    check_output("abort_start_seen", 64'(n < 50), 64'd1);
    repeat (5) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check_output("abort_k_reset_low", 64'(k_reset), 64'd0);
    n = 0;
    while (busy && n < 50) begin @(negedge clock); n++; end
    check_output("abort_idle", 64'(busy), 64'd0);
    check_output("abort_results_left", 64'(exp_res_q.size()), 64'd0);

    $display("[TB] go with an empty mask");
    apply_stimulus(4'b0000, 2, 10);
    wait_seq_done("empty_mask", 50);

    $display("[TB] statistics sequence");
    plan_q = '{11, 29, 17};
    apply_stimulus(4'b0001, 3, 100);
    wait_seq_done("stats", 2000);

    $display("[TB] randomized sequences");
    for (int it = 0; it < 25; it++) begin
      logic [3:0] m;
      int         rn, tm;
      ready_pct = $urandom_range(30, 100);
      m  = 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
      tm = $urandom_range(2, 30);
      apply_stimulus(m, rn, tm);
      wait_seq_done("rand", 8000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
